// File: rtl/multicycle_controller_if.sv
// Control/handshake bundle between the multi-cycle controller and the datapath/memories.
interface multicycle_controller_if;
  logic [31:0] instr_in;
  logic        imem_ready;
  logic        dmem_ready;
  logic        flag_z;
  logic        flag_n;
  logic        imem_req;
  logic        ir_load;
  logic [3:0]  alu_sel;
  logic        flags_wr;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        reg_wr;
  logic [1:0]  wb_sel;
  logic        pc_wr;
  logic [1:0]  pc_sel;
  logic        busy;
  logic        err;

  modport master (
    input  instr_in, imem_ready, dmem_ready, flag_z, flag_n,
    output imem_req, ir_load, alu_sel, flags_wr, dmem_rd, dmem_wr,
           reg_wr, wb_sel, pc_wr, pc_sel, busy, err
  );

  modport slave (
    output instr_in, imem_ready, dmem_ready, flag_z, flag_n,
    input  imem_req, ir_load, alu_sel, flags_wr, dmem_rd, dmem_wr,
           reg_wr, wb_sel, pc_wr, pc_sel, busy, err
  );
endinterface

// File: rtl/multicycle_controller.sv
// Multi-cycle CPU control FSM: fetch, decode, execute, memory, write-back sequencing
// with req/ready memory handshakes and a watchdog that traps a stalled memory.
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  localparam int unsigned OPC_W = 4;
  localparam int unsigned ALU_W = 4;
  localparam int unsigned SEL_W = 2;
  localparam int unsigned CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  localparam logic [OPC_W-1:0] OP_NOP  = 4'b0000;
  localparam logic [OPC_W-1:0] OP_ST   = 4'b0011;
  localparam logic [OPC_W-1:0] OP_ADD  = 4'b0100;
  localparam logic [OPC_W-1:0] OP_INC  = 4'b0101;
  localparam logic [OPC_W-1:0] OP_NEG  = 4'b0110;
  localparam logic [OPC_W-1:0] OP_SUB  = 4'b0111;
  localparam logic [OPC_W-1:0] OP_J    = 4'b1000;
  localparam logic [OPC_W-1:0] OP_BRZ  = 4'b1001;
  localparam logic [OPC_W-1:0] OP_JM   = 4'b1010;
  localparam logic [OPC_W-1:0] OP_BRN  = 4'b1011;
  localparam logic [OPC_W-1:0] OP_LD   = 4'b1110;
  localparam logic [OPC_W-1:0] OP_SVPC = 4'b1111;

  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_INC  = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_NEG  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0011;
  localparam logic [ALU_W-1:0] ALU_PASS = 4'b0100;

  localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
  localparam logic [SEL_W-1:0] WB_MEM = 2'b01;
  localparam logic [SEL_W-1:0] WB_PC  = 2'b10;

  localparam logic [SEL_W-1:0] PC_INC = 2'b00;
  localparam logic [SEL_W-1:0] PC_RS  = 2'b01;
  localparam logic [SEL_W-1:0] PC_MEM = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_ERR
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic [OPC_W-1:0]   opcode;
  logic [OPC_W-1:0]   opcode_nx;
  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_cnt_nx;

  logic               is_alu;
  logic               is_mem;
  logic               timeout_hit;
  logic [ALU_W-1:0]   alu_op;
  logic               instr_unused;

  logic               imem_req;
  logic               ir_load;
  logic [ALU_W-1:0]   alu_sel;
  logic               flags_wr;
  logic               dmem_rd;
  logic               dmem_wr;
  logic               reg_wr;
  logic [SEL_W-1:0]   wb_sel;
  logic               pc_wr;
  logic [SEL_W-1:0]   pc_sel;
  logic               busy;
  logic               err;

  // Only the opcode field is consumed here; the rest of the word goes to the IR.
  assign instr_unused = ^bus.instr_in[27:0];

  assign is_alu = (opcode == OP_ADD) || (opcode == OP_INC) ||
                  (opcode == OP_NEG) || (opcode == OP_SUB);
  assign is_mem = (opcode == OP_LD) || (opcode == OP_ST) || (opcode == OP_JM);

  // Wait counter reaching the limit with ready still low traps the FSM.
  assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    alu_op = ALU_ADD;
    unique case (opcode)
      OP_ADD:                  alu_op = ALU_ADD;
      OP_INC:                  alu_op = ALU_INC;
      OP_NEG:                  alu_op = ALU_NEG;
      OP_SUB:                  alu_op = ALU_SUB;
      OP_LD, OP_ST, OP_JM:     alu_op = ALU_PASS;
      default:                 alu_op = ALU_ADD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      opcode   <= OP_NOP;
      wait_cnt <= '0;
    end else begin
      state    <= state_nx;
      opcode   <= opcode_nx;
      wait_cnt <= wait_cnt_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    opcode_nx   = opcode;
    wait_cnt_nx = '0;
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    alu_sel     = ALU_ADD;
    flags_wr    = 1'b0;
    dmem_rd     = 1'b0;
    dmem_wr     = 1'b0;
    reg_wr      = 1'b0;
    wb_sel      = WB_ALU;
    pc_wr       = 1'b0;
    pc_sel      = PC_INC;
    busy        = 1'b0;
    err         = 1'b0;

    unique case (state)
      S_IDLE: begin
        state_nx = S_FETCH;
      end

      S_FETCH: begin
        busy     = 1'b1;
        imem_req = 1'b1;
        if (bus.imem_ready) begin
          ir_load   = 1'b1;
          opcode_nx = bus.instr_in[31:28];
          state_nx  = S_DECODE;
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end

      S_DECODE: begin
        busy     = 1'b1;
        state_nx = (is_alu || is_mem) ? S_EXEC : S_WB;
      end

      S_EXEC: begin
        busy     = 1'b1;
        alu_sel  = alu_op;
        flags_wr = is_alu;
        state_nx = is_mem ? S_MEM : S_WB;
      end

      S_MEM: begin
        busy    = 1'b1;
        alu_sel = alu_op;
        dmem_rd = (opcode == OP_LD) || (opcode == OP_JM);
        dmem_wr = (opcode == OP_ST);
        if (bus.dmem_ready) begin
          state_nx = S_WB;
        end else if (timeout_hit) begin
          state_nx = S_ERR;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end

      S_WB: begin
        busy     = 1'b1;
        alu_sel  = alu_op;
        pc_wr    = 1'b1;
        state_nx = S_FETCH;
        if (is_alu) begin
          reg_wr = 1'b1;
          wb_sel = WB_ALU;
        end
        unique case (opcode)
          OP_LD: begin
            reg_wr = 1'b1;
            wb_sel = WB_MEM;
          end
          OP_SVPC: begin
            reg_wr = 1'b1;
            wb_sel = WB_PC;
          end
          OP_J:    pc_sel = PC_RS;
          OP_JM:   pc_sel = PC_MEM;
          OP_BRZ:  pc_sel = bus.flag_z ? PC_RS : PC_INC;
          OP_BRN:  pc_sel = bus.flag_n ? PC_RS : PC_INC;
          default: pc_sel = PC_INC;
        endcase
      end

      S_ERR: begin
        err = 1'b1;
      end

      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  assign bus.imem_req = imem_req;
  assign bus.ir_load  = ir_load;
  assign bus.alu_sel  = alu_sel;
  assign bus.flags_wr = flags_wr;
  assign bus.dmem_rd  = dmem_rd;
  assign bus.dmem_wr  = dmem_wr;
  assign bus.reg_wr   = reg_wr;
  assign bus.wb_sel   = wb_sel;
  assign bus.pc_wr    = pc_wr;
  assign bus.pc_sel   = pc_sel;
  assign bus.busy     = busy;
  assign bus.err      = err;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (watchdog limit set to 4).
module tb_multicycle_controller;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic [3:0] alu_sel;
    logic       flags_wr;
    logic       dmem_rd;
    logic       dmem_wr;
    logic       reg_wr;
    logic [1:0] wb_sel;
    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       busy;
    logic       err;
  } outs_t;

  typedef struct packed {
    logic       r;
    logic [3:0] op;
    logic       ir;
    logic       dr;
    logic       fz;
    logic       fn;
    outs_t      exp;
  } row_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  multicycle_controller_if bus ();

  multicycle_controller #(.MEM_TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic outs_t sample();
    outs_t o;
    o.imem_req = bus.imem_req;
    o.ir_load  = bus.ir_load;
    o.alu_sel  = bus.alu_sel;
    o.flags_wr = bus.flags_wr;
    o.dmem_rd  = bus.dmem_rd;
    o.dmem_wr  = bus.dmem_wr;
    o.reg_wr   = bus.reg_wr;
    o.wb_sel   = bus.wb_sel;
    o.pc_wr    = bus.pc_wr;
    o.pc_sel   = bus.pc_sel;
    o.busy     = bus.busy;
    o.err      = bus.err;
    return o;
  endfunction

  function automatic outs_t o_idle();
    outs_t o = '0;
    return o;
  endfunction

  function automatic outs_t o_fetch(input logic ld);
    outs_t o = '0;
    o.imem_req = 1'b1;
    o.ir_load  = ld;
    o.busy     = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_dec();
    outs_t o = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_exec(input logic [3:0] alu, input logic fw);
    outs_t o = '0;
    o.alu_sel  = alu;
    o.flags_wr = fw;
    o.busy     = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_mem(input logic [3:0] alu, input logic rd, input logic wr);
    outs_t o = '0;
    o.alu_sel = alu;
    o.dmem_rd = rd;
    o.dmem_wr = wr;
    o.busy    = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_wb(input logic [3:0] alu, input logic rw,
                                 input logic [1:0] wbs, input logic [1:0] pcs);
    outs_t o = '0;
    o.alu_sel = alu;
    o.reg_wr  = rw;
    o.wb_sel  = wbs;
    o.pc_wr   = 1'b1;
    o.pc_sel  = pcs;
    o.busy    = 1'b1;
    return o;
  endfunction

  function automatic outs_t o_err();
    outs_t o = '0;
    o.err = 1'b1;
    return o;
  endfunction

  function automatic row_t mkrow(input logic r, input logic [3:0] op, input logic ir,
                                 input logic dr, input logic fz, input logic fn,
                                 input outs_t e);
    row_t x;
    x.r = r; x.op = op; x.ir = ir; x.dr = dr; x.fz = fz; x.fn = fn; x.exp = e;
    return x;
  endfunction

  // Apply one cycle of inputs just after the falling edge, then let outputs settle.
  task automatic drive(input row_t x);
    @(negedge clk);
    rst            = x.r;
    bus.instr_in   = {x.op, 28'h0ABCDEF};
    bus.imem_ready = x.ir;
    bus.dmem_ready = x.dr;
    bus.flag_z     = x.fz;
    bus.flag_n     = x.fn;
    #1;
  endtask

  task automatic test_reset();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(1, 4'h4, 0, 0, 0, 0, o_idle()));
    q.push_back(mkrow(1, 4'h4, 1, 1, 1, 1, o_idle()));
    q.push_back(mkrow(0, 4'h4, 1, 1, 0, 0, o_idle()));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL reset[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_add();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(0, 4'h4, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 1, 1, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 1, 1, 0, 0, o_exec(4'b0000, 1)));
    q.push_back(mkrow(0, 4'h0, 0, 1, 0, 0, o_wb(4'b0000, 1, 2'b00, 2'b00)));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL add[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_ld_wait();
    row_t  q[$];
    outs_t obs;
    int    rd_cycles;
    q.push_back(mkrow(0, 4'h4, 0, 0, 0, 0, o_fetch(0)));
    q.push_back(mkrow(0, 4'hE, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_exec(4'b0100, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 1, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 1, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 1, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 1, 0, 0, o_mem(4'b0100, 1, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_wb(4'b0100, 1, 2'b01, 2'b00)));
    rd_cycles = 0;
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      if (obs.dmem_rd === 1'b1) rd_cycles++;
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL ld_wait[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
    n_cmp++;
    if (rd_cycles !== 4) begin
      $display("FAIL ld_rd_cycles got=%0d expected=4", rd_cycles);
      n_bad++;
    end
  endtask

  task automatic test_branch();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(0, 4'h9, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 1, 0, o_wb(4'b0000, 0, 2'b00, 2'b01)));
    q.push_back(mkrow(0, 4'h9, 1, 0, 1, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 1, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 1, o_wb(4'b0000, 0, 2'b00, 2'b00)));
    q.push_back(mkrow(0, 4'hB, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 1, o_wb(4'b0000, 0, 2'b00, 2'b01)));
    q.push_back(mkrow(0, 4'hB, 1, 0, 0, 1, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 1, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 1, 0, o_wb(4'b0000, 0, 2'b00, 2'b00)));
    q.push_back(mkrow(0, 4'h8, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_wb(4'b0000, 0, 2'b00, 2'b01)));
    q.push_back(mkrow(0, 4'hF, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_wb(4'b0000, 1, 2'b10, 2'b00)));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL branch[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_jm();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(0, 4'hA, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_exec(4'b0100, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 1, 0, 0, o_mem(4'b0100, 1, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_wb(4'b0100, 0, 2'b00, 2'b10)));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL jm[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_undef_neg();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(0, 4'hD, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_wb(4'b0000, 0, 2'b00, 2'b00)));
    q.push_back(mkrow(0, 4'h6, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_exec(4'b0010, 1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_wb(4'b0010, 1, 2'b00, 2'b00)));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL undef_neg[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_reset_mid();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(0, 4'h3, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_exec(4'b0100, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 0, 1)));
    q.push_back(mkrow(1, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 0, 1)));
    q.push_back(mkrow(0, 4'h0, 0, 1, 0, 0, o_idle()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_fetch(0)));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL reset_mid[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  task automatic test_timeout();
    row_t  q[$];
    outs_t obs;
    q.push_back(mkrow(0, 4'h3, 1, 0, 0, 0, o_fetch(1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_dec()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_exec(4'b0100, 0)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 0, 1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 0, 1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 0, 1)));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_mem(4'b0100, 0, 1)));
    q.push_back(mkrow(0, 4'h0, 1, 1, 0, 0, o_err()));
    q.push_back(mkrow(0, 4'h4, 1, 1, 1, 1, o_err()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_err()));
    q.push_back(mkrow(1, 4'h0, 0, 0, 0, 0, o_err()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_idle()));
    q.push_back(mkrow(0, 4'h0, 0, 0, 0, 0, o_fetch(0)));
    for (int i = 0; i < q.size(); i++) begin
      drive(q[i]);
      obs = sample();
      n_cmp++;
      if (obs !== q[i].exp) begin
        $display("FAIL timeout[%0d] got=%h expected=%h", i, obs, q[i].exp);
        n_bad++;
      end
    end
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    rst            = 1'b1;
    bus.instr_in   = 32'h0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.flag_z     = 1'b0;
    bus.flag_n     = 1'b0;
    test_reset();
    test_add();
    test_ld_wait();
    test_branch();
    test_jm();
    test_undef_neg();
    test_reset_mid();
    test_timeout();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
